// File: rtl/pipeline_if_pkg.sv
// pipeline_if_pkg: shared constants and FSM state encoding for the fetch stage
package pipeline_if_pkg;
  localparam int INST_ADDR_WIDTH = 32;
  localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } if_state_e;
endpackage

// File: rtl/pipeline_if_skid_buffer.sv
// pipeline_if_skid_buffer: one-entry inst+pc holding register used while downstream stalls
module pipeline_if_skid_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [INST_WIDTH-1:0] load_inst,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  valid
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end
endmodule

// File: rtl/pipeline_if.sv
// pipeline_if: instruction fetch stage with single-outstanding imem handshake, stall skid and branch redirect
module pipeline_if import pipeline_if_pkg::*; #(
  parameter int                    ADDR_WIDTH = INST_ADDR_WIDTH,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(IF_NOP_INST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_tag,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  inst_valid
);
  if_state_e state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc, hold_addr, target, skid_pc;
  logic [INST_WIDTH-1:0] skid_inst;
  logic take, drain, skid_valid;
  assign target = branch_target & ~ADDR_WIDTH'(3);
  assign take   = state == S_REQ && imem_ready && !branch_tag;
  assign drain  = state == S_HOLD && !stall && !branch_tag;
  pipeline_if_skid_buffer #(.ADDR_WIDTH(ADDR_WIDTH), .INST_WIDTH(INST_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (take && stall),
    .clear     (branch_tag || drain),
    .load_inst (imem_data),
    .load_pc   (fetch_pc),
    .inst      (skid_inst),
    .pc        (skid_pc),
    .valid     (skid_valid)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = S_REQ;
      S_REQ:     state_nxt = branch_tag ? (imem_ready ? S_REQ : S_DISCARD)
                                        : (imem_ready && stall) ? S_HOLD : S_REQ;
      S_HOLD:    state_nxt = (branch_tag || !stall) ? S_REQ : S_HOLD;
      S_DISCARD: state_nxt = imem_ready ? S_REQ : S_DISCARD;
      default:   state_nxt = S_IDLE;
    endcase
  end
  // the abandoned request keeps its original address until memory answers it
  always_comb begin
    imem_req  = state == S_REQ || state == S_DISCARD;
    imem_addr = state == S_DISCARD ? hold_addr : fetch_pc;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc   <= RESET_PC;
      hold_addr  <= RESET_PC;
      inst       <= NOP_INST;
      pc         <= '0;
      inst_valid <= 1'b0;
    end else begin
      if (branch_tag)  fetch_pc <= target;
      else if (take)   fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      if (branch_tag && state == S_REQ && !imem_ready) hold_addr <= fetch_pc;
      if (branch_tag) begin
        inst       <= NOP_INST;
        inst_valid <= 1'b0;
      end else if (take && !stall) begin
        inst       <= imem_data;
        pc         <= fetch_pc;
        inst_valid <= 1'b1;
      end else if (drain) begin
        inst       <= skid_inst;
        pc         <= skid_pc;
        inst_valid <= skid_valid;
      end else if (state == S_REQ && !imem_ready && !stall) begin
        inst       <= NOP_INST;
        inst_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_pipeline_if.sv
// tb_pipeline_if: directed stimulus with a queue-based fetch model and literal spot checks
module tb_pipeline_if;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {logic [31:0] i; logic [31:0] p;} item_t;
  logic clk = 1'b0;
  logic rst, stall, branch_tag, imem_ready, imem_req, inst_valid;
  logic [31:0] branch_target, imem_addr, imem_data, inst, pc;
  logic req2, valid2;
  logic [31:0] addr2, data2, inst2, pc2;
  int checks = 0, errors = 0;
  bit started, m_drop, m_valid, exp_req;
  logic [31:0] m_fetch, m_old, m_inst, m_pc, exp_addr;
  item_t skid[$];

  assign imem_data = ~imem_addr;
  assign data2 = ~addr2;

  pipeline_if dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_tag(branch_tag), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .inst(inst), .pc(pc), .inst_valid(inst_valid)
  );

  pipeline_if #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_tag(1'b0), .branch_target(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(1'b1), .imem_data(data2),
    .inst(inst2), .pc(pc2), .inst_valid(valid2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory answers every address a with ~a; responses consumed while stalled wait in the skid queue
  task automatic model_step();
    bit req_now;
    logic [31:0] resp_addr;
    if (!rst) begin
      started = 0; m_fetch = 32'h0; m_old = 32'h0; m_drop = 0; skid.delete();
      m_inst = NOP; m_pc = 32'h0; m_valid = 0;
    end else begin
      req_now = started && skid.size() == 0;
      resp_addr = m_drop ? m_old : m_fetch;
      if (branch_tag) begin
        if (m_drop) m_drop = !imem_ready;
        else if (req_now && !imem_ready) begin m_drop = 1; m_old = m_fetch; end
        m_fetch = branch_target & ~32'h3;
        skid.delete();
        m_inst = NOP; m_valid = 0;
      end else if (req_now && imem_ready && m_drop) begin
        m_drop = 0;
      end else if (req_now && imem_ready) begin
        if (stall) skid.push_back('{~resp_addr, resp_addr});
        else begin m_inst = ~resp_addr; m_pc = resp_addr; m_valid = 1; end
        m_fetch = m_fetch + 32'd4;
      end else if (skid.size() != 0 && !stall) begin
        m_inst = skid[0].i; m_pc = skid[0].p; m_valid = 1;
        skid.delete(0);
      end else if (req_now && !stall) begin
        m_inst = NOP; m_valid = 0;
      end
      started = 1;
    end
    exp_req = started && skid.size() == 0;
    exp_addr = m_drop ? m_old : m_fetch;
  endtask

  task automatic compare();
    if (rst) begin
      chk("req", imem_req, exp_req);
      if (exp_req) chk("addr", imem_addr, exp_addr);
      chk("valid", inst_valid, m_valid);
      chk("inst", inst, m_inst);
      if (m_valid) chk("pc", pc, m_pc);
    end
  endtask

  always @(posedge clk or negedge rst) model_step();
  always @(negedge clk) compare();

  task automatic cyc(input bit r, input bit s, input bit b, input logic [31:0] t);
    imem_ready = r; stall = s; branch_tag = b; branch_target = t;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; stall = 0; branch_tag = 0; imem_ready = 0; branch_target = 0;
    #1 rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0); chk("rst_addr", imem_addr, 0); chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 0); chk("rst_valid", inst_valid, 0); chk("rst_addr2", addr2, 32'hFFFF_FFF8);
    rst = 1;
    cyc(1, 0, 0, 0);
    chk("w1_req", imem_req, 1); chk("w1_addr", imem_addr, 0); chk("w1_valid", inst_valid, 0);
    chk("d2_w1_addr", addr2, 32'hFFFF_FFF8);
    cyc(1, 0, 0, 0);
    chk("w2_pc", pc, 0); chk("w2_inst", inst, 32'hFFFF_FFFF); chk("w2_valid", inst_valid, 1);
    chk("w2_addr", imem_addr, 4); chk("d2_w2_pc", pc2, 32'hFFFF_FFF8); chk("d2_w2_addr", addr2, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("w3_pc", pc, 4); chk("w3_addr", imem_addr, 8);
    chk("d2_w3_pc", pc2, 32'hFFFF_FFFC); chk("d2_w3_inst", inst2, 32'h0000_0003); chk("d2_w3_addr", addr2, 0);
    cyc(0, 0, 0, 0);
    chk("w4_valid", inst_valid, 0); chk("w4_inst", inst, NOP); chk("w4_addr", imem_addr, 8);
    chk("d2_w4_pc", pc2, 0); chk("d2_w4_valid", valid2, 1); chk("d2_w4_req", req2, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("w6_addr", imem_addr, 8); chk("w6_valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("w7_pc", pc, 8); chk("w7_inst", inst, 32'hFFFF_FFF7); chk("w7_valid", inst_valid, 1);
    cyc(1, 0, 0, 0);
    chk("w8_pc", pc, 32'hC); chk("w8_addr", imem_addr, 32'h10);
    cyc(1, 1, 0, 0);
    chk("w9_req", imem_req, 0); chk("w9_pc", pc, 32'hC);
    repeat (3) cyc(1, 1, 0, 0);
    chk("w12_req", imem_req, 0); chk("w12_pc", pc, 32'hC); chk("w12_valid", inst_valid, 1);
    cyc(1, 0, 0, 0);
    chk("w13_pc", pc, 32'h10); chk("w13_valid", inst_valid, 1); chk("w13_addr", imem_addr, 32'h14);
    cyc(0, 0, 0, 0);
    chk("w14_valid", inst_valid, 0); chk("w14_addr", imem_addr, 32'h14);
    cyc(1, 0, 0, 0);
    chk("w15_pc", pc, 32'h14);
    cyc(1, 0, 1, 32'h40);
    chk("w16_valid", inst_valid, 0); chk("w16_inst", inst, NOP); chk("w16_addr", imem_addr, 32'h40);
    cyc(0, 0, 1, 32'h203);
    chk("w17_req", imem_req, 1); chk("w17_addr", imem_addr, 32'h40);
    cyc(0, 0, 0, 0);
    chk("w18_addr", imem_addr, 32'h40); chk("w18_valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("w19_addr", imem_addr, 32'h200); chk("w19_valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("w20_pc", pc, 32'h200); chk("w20_inst", inst, 32'hFFFF_FDFF); chk("w20_addr", imem_addr, 32'h204);
    cyc(0, 1, 1, 32'h300);
    chk("w21_valid", inst_valid, 0); chk("w21_inst", inst, NOP); chk("w21_addr", imem_addr, 32'h204);
    cyc(1, 1, 0, 0);
    chk("w22_addr", imem_addr, 32'h300);
    cyc(1, 1, 0, 0);
    chk("w23_req", imem_req, 0); chk("w23_valid", inst_valid, 0);
    cyc(0, 1, 0, 0);
    chk("w24_inst", inst, NOP); chk("w24_valid", inst_valid, 0);
    cyc(0, 0, 0, 0);
    chk("w25_pc", pc, 32'h300); chk("w25_valid", inst_valid, 1); chk("w25_addr", imem_addr, 32'h304);
    cyc(0, 0, 1, 32'h500);
    cyc(0, 0, 1, 32'h600);
    chk("w27_addr", imem_addr, 32'h304);
    cyc(1, 0, 0, 0);
    chk("w28_addr", imem_addr, 32'h600);
    cyc(1, 0, 0, 0);
    chk("w29_pc", pc, 32'h600);
    cyc(1, 1, 0, 0);
    chk("w30_req", imem_req, 0);
    cyc(0, 1, 1, 32'h700);
    chk("w31_addr", imem_addr, 32'h700); chk("w31_valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("w32_pc", pc, 32'h700);
    cyc(0, 0, 0, 0);
    chk("w33_req", imem_req, 1); chk("w33_addr", imem_addr, 32'h704);
    #2 rst = 0;
    #1 chk("arst_req", imem_req, 0); chk("arst_addr", imem_addr, 0);
    chk("arst_valid", inst_valid, 0); chk("arst_inst", inst, NOP);
    cyc(1, 0, 0, 0);
    rst = 1;
    cyc(1, 0, 0, 0);
    chk("rel_req", imem_req, 1); chk("rel_addr", imem_addr, 0); chk("rel_valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("rel2_pc", pc, 0); chk("rel2_valid", inst_valid, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
